// File: rtl/elixirchip_es1_spu_lut_arbiter_pkg.sv
// Shared types for the SPU LUT arbiter: result tag carried alongside the
// LUT op unit's latency, and the requester-index width helper.
package elixirchip_es1_spu_lut_arbiter_pkg;

  // Wide enough for the largest supported requester count (16).
  localparam int TAG_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_lut_arb_tag_pipe.sv
// Clock-enabled tag delay line matching the LUT op unit latency;
// a plain wire when the LUT unit is combinational.
module elixirchip_es1_spu_lut_arb_tag_pipe
  import elixirchip_es1_spu_lut_arbiter_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cke,
  input  tag_t tag_i,
  output tag_t tag_o
);

  if (LATENCY == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = clk ^ reset_n ^ cke;
    assign tag_o      = tag_i;
  end else begin : g_pipe
    tag_t stage_q [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < LATENCY; s++) stage_q[s] <= '0;
      end else if (cke) begin
        stage_q[0] <= tag_i;
        for (int s = 1; s < LATENCY; s++) stage_q[s] <= stage_q[s-1];
      end
    end

    assign tag_o = stage_q[LATENCY-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_lut_arbiter.sv
// Round-robin arbiter sharing one fixed-latency LUT op unit between N_REQ
// requesters; results are routed back by a tag travelling beside the LUT.
module elixirchip_es1_spu_lut_arbiter
  import elixirchip_es1_spu_lut_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int LATENCY   = 1,
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cke,
  input  logic [N_REQ-1:0]                   s_valid,
  output logic [N_REQ-1:0]                   s_ready,
  input  logic [N_REQ-1:0][ADDR_BITS-1:0]    s_addr,
  input  logic [N_REQ-1:0]                   s_clear,
  output logic [ADDR_BITS-1:0]               lut_addr,
  output logic                               lut_clear,
  output logic                               lut_valid,
  input  logic [DATA_BITS-1:0]               lut_data,
  output logic [N_REQ-1:0]                   m_valid,
  output logic [$clog2(N_REQ)-1:0]           m_id,
  output logic [DATA_BITS-1:0]               m_data
);

  localparam int ID_W = id_width(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  // Returns {found, index}; scanning k downward lets the nearest index
  // after ptr overwrite farther ones, so the first active one wins.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] act,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (act[idx]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ADDR_BITS-1:0] lut_addr_q, lut_addr_d;
  logic [N_REQ-1:0]     active;
  logic [ID_W:0]        pick;
  logic [ID_W-1:0]      win;
  logic                 xfer;
  tag_t                 tag_in, tag_out;

  assign active = s_valid | s_clear;
  assign pick   = rr_pick(active, ptr_q);
  assign win    = pick[ID_W-1:0];
  assign xfer   = cke & pick[ID_W];

  assign s_ready    = xfer ? (ONE << win) : '0;
  assign lut_clear  = xfer & s_clear[win];
  assign lut_valid  = xfer & s_valid[win] & ~s_clear[win];
  assign lut_addr_d = xfer ? s_addr[win] : lut_addr_q;
  assign lut_addr   = lut_addr_d;
  assign ptr_d      = xfer ? win : ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= ID_W'(N_REQ - 1);
      lut_addr_q <= '0;
    end else if (cke) begin
      ptr_q      <= ptr_d;
      lut_addr_q <= lut_addr_d;
    end
  end

  // Idle cycles push a zero id so m_id reads 0 when nothing is in flight.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = xfer;
    if (xfer) tag_in.id = TAG_ID_W'(win);
  end

  elixirchip_es1_spu_lut_arb_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .tag_i   (tag_in),
    .tag_o   (tag_out)
  );

  logic unused_id_hi;
  assign unused_id_hi = ^tag_out.id;

  assign m_valid = (cke & tag_out.valid) ? (ONE << tag_out.id[ID_W-1:0]) : '0;
  assign m_id    = tag_out.id[ID_W-1:0];
  assign m_data  = lut_data;

endmodule

// File: tb/tb_elixirchip_es1_spu_lut_arbiter.sv
// Directed bench: three arbiters (LATENCY 0/1/3) share stimulus, each with a
// behavioural LUT unit; expected grants are hand-listed per cycle.
module tb_elixirchip_es1_spu_lut_arbiter;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  cke;
  logic [3:0]            s_valid, s_clear;
  logic [3:0][5:0]       s_addr;
  logic [2:0][3:0]       rdy, mv;
  logic [2:0][5:0]       la;
  logic [2:0]            lc, lv;
  logic [2:0][1:0]       mid;
  logic [2:0][7:0]       md, ld;

  int n_cmp = 0, n_bad = 0, cyc_n = 0;
  int lats [3] = '{0, 1, 3};
  int addr_tab [4] = '{3, 9, 5, 12};
  int hid[$], hdat[$];
  int last_addr;

  always #5 clk = ~clk;

  function automatic logic [7:0] lutf(input logic [5:0] a, input logic c);
    return c ? 8'hA5 : 8'(int'(a) * 7 + 3);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 0 : ((k == 1) ? 1 : 3);

    elixirchip_es1_spu_lut_arbiter #(
      .N_REQ(4), .LATENCY(L), .ADDR_BITS(6), .DATA_BITS(8)
    ) dut (
      .clk(clk), .reset_n(reset_n), .cke(cke),
      .s_valid(s_valid), .s_ready(rdy[k]), .s_addr(s_addr), .s_clear(s_clear),
      .lut_addr(la[k]), .lut_clear(lc[k]), .lut_valid(lv[k]), .lut_data(ld[k]),
      .m_valid(mv[k]), .m_id(mid[k]), .m_data(md[k])
    );

    if (L == 0) begin : g_lut0
      assign ld[k] = lutf(la[k], lc[k]);
    end else begin : g_lutn
      logic [7:0] dq [L];
      always @(posedge clk) begin
        if (cke) begin
          dq[0] <= lutf(la[k], lc[k]);
          for (int j = 1; j < L; j++) dq[j] <= dq[j-1];
        end
      end
      assign ld[k] = dq[L-1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc_n, got, exp);
    end
  endtask

  // One clock: drive, check combinational and result outputs, advance.
  task automatic cyc(input logic [3:0] v, input logic [3:0] c, input logic ck, input int eg);
    int         eid, edat;
    logic [7:0] ed;
    s_valid = v; s_clear = c; cke = ck;
    #2;
    ed = (eg >= 0) ? lutf(6'(addr_tab[eg]), c[eg]) : 8'h0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("L%0d.s_ready", lats[k]), 32'(rdy[k]), (eg >= 0) ? (32'd1 << eg) : 32'd0);
    chk("lut_valid", 32'(lv[1]), 32'((eg >= 0) && v[eg] && !c[eg]));
    chk("lut_clear", 32'(lc[1]), 32'((eg >= 0) && c[eg]));
    chk("lut_addr",  32'(la[1]), (eg >= 0) ? addr_tab[eg] : last_addr);
    for (int k = 0; k < 3; k++) begin
      eid = -1; edat = 0;
      if (ck) begin
        if (lats[k] == 0) begin
          eid = eg; edat = int'(ed);
        end else if (hid.size() >= lats[k]) begin
          eid = hid[lats[k]-1]; edat = hdat[lats[k]-1];
        end
      end
      chk($sformatf("L%0d.m_valid", lats[k]), 32'(mv[k]), (eid >= 0) ? (32'd1 << eid) : 32'd0);
      if (eid >= 0) begin
        chk($sformatf("L%0d.m_id", lats[k]),   32'(mid[k]), eid);
        chk($sformatf("L%0d.m_data", lats[k]), 32'(md[k]),  edat);
      end
    end
    if (ck) begin
      hid.push_front(eg);
      hdat.push_front(int'(ed));
      if (hid.size() > 8) begin
        void'(hid.pop_back());
        void'(hdat.pop_back());
      end
      if (eg >= 0) last_addr = addr_tab[eg];
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; s_valid = '0; s_clear = '0; cke = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst L%0d.m_valid", lats[k]), 32'(mv[k]),  32'd0);
      chk($sformatf("rst L%0d.m_id", lats[k]),    32'(mid[k]), 32'd0);
      chk($sformatf("rst L%0d.s_ready", lats[k]), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst L%0d.lut_addr", lats[k]), 32'(la[k]), 32'd0);
    end
    hid.delete(); hdat.delete(); last_addr = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] all_v;
    all_v = 4'hF;
    for (int i = 0; i < 4; i++) s_addr[i] = 6'(addr_tab[i]);
    reset_n = 1'b0; cke = 1'b0; s_valid = '0; s_clear = '0; last_addr = 0;
    @(posedge clk); #1;
    do_reset();

    // All requesters valid from reset: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) cyc(all_v, 4'h0, 1'b1, i % 4);
    // Single requester keeps full throughput
    for (int i = 0; i < 4; i++) cyc(4'b0100, 4'h0, 1'b1, 2);
    // Clear beats valid from the same requester
    cyc(4'b0010, 4'b0010, 1'b1, 1);
    cyc(4'b0000, 4'b0000, 1'b1, -1);
    // Stall mid-stream
    cyc(all_v, 4'h0, 1'b1, 2);
    cyc(all_v, 4'h0, 1'b1, 3);
    for (int i = 0; i < 3; i++) cyc(all_v, 4'h0, 1'b0, -1);
    cyc(all_v, 4'h0, 1'b1, 0);
    cyc(all_v, 4'h0, 1'b1, 1);
    cyc(all_v, 4'h0, 1'b1, 2);
    // Requester drops valid before being granted: ptr holds at 2
    cyc(4'b0001, 4'h0, 1'b0, -1);
    cyc(4'b0000, 4'h0, 1'b1, -1);
    cyc(all_v, 4'h0, 1'b1, 3);
    // Reset with operations in flight
    cyc(all_v, 4'h0, 1'b1, 0);
    cyc(all_v, 4'h0, 1'b1, 1);
    do_reset();
    cyc(all_v, 4'h0, 1'b1, 0);
    // Requesters 0 and 3 alternate
    cyc(4'b1001, 4'h0, 1'b1, 3);
    cyc(4'b1001, 4'h0, 1'b1, 0);
    cyc(4'b1001, 4'h0, 1'b1, 3);
    cyc(4'b1001, 4'h0, 1'b1, 0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 4'h0, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
